// File: rtl/chr_vram_arbiter.sv
// chr_vram_arbiter: single-port character VRAM shared by a fixed-latency display fetcher and a host req/ack port.
// Define CHR_VRAM_ARB_BLANK_ONLY_EN to restrict host accesses to vertical blanking.
module chr_vram_arbiter #(
    parameter int C_H_ACT_ST    = 122,
    parameter int C_H_SIZE      = 720,
    parameter int C_V_ACT_ST    = 36,
    parameter int C_V_SIZE      = 480,
    parameter int C_CELL_W_LOG2 = 3,
    parameter int C_CELL_H_LOG2 = 4,
    parameter int C_PITCH_LOG2  = 7,
    parameter int C_ADR_W       = 12,
    parameter int C_DAT_W       = 8
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               CKE_i,
    input  logic [15:0]        H_CTR_i,
    input  logic [15:0]        V_CTR_i,
    input  logic               XV_BLANK_i,
    input  logic               HOST_REQ_i,
    input  logic               HOST_WE_i,
    input  logic [C_ADR_W-1:0] HOST_ADR_i,
    input  logic [C_DAT_W-1:0] HOST_WD_i,
    output logic               HOST_ACK_o,
    output logic [C_DAT_W-1:0] HOST_RD_o,
    output logic               MEM_EN_o,
    output logic               MEM_WE_o,
    output logic [C_ADR_W-1:0] MEM_ADR_o,
    output logic [C_DAT_W-1:0] MEM_WD_o,
    input  logic [C_DAT_W-1:0] MEM_RD_i,
    output logic [C_DAT_W-1:0] CHR_CODE_o,
    output logic [7:0]         CHR_COL_o,
    output logic               CHR_VLD_o
);
    // Fetch runs one cell ahead of the active pixels so the glyph is ready in time.
    localparam logic [15:0] H_FETCH_ST = 16'(C_H_ACT_ST - 2 ** C_CELL_W_LOG2);
    localparam logic [15:0] H_SZ       = 16'(C_H_SIZE);
    localparam logic [15:0] V_ST       = 16'(C_V_ACT_ST);
    localparam logic [15:0] V_SZ       = 16'(C_V_SIZE);
    localparam logic [1:0] TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_HRD = 2'd2, TAG_HWR = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    state_t state_q, state_d;

    logic [15:0]        h_off, v_off;
    logic               trig, host_go;
    logic [7:0]         disp_col;
    logic [C_ADR_W-1:0] disp_adr;
    logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [C_ADR_W-1:0] mem_adr_q, mem_adr_d;
    logic [C_DAT_W-1:0] mem_wd_q, mem_wd_d;
    logic [1:0]         tag1_q, tag1_d, tag2_q;
    logic [7:0]         col1_q, col1_d, col2_q;
    logic [C_DAT_W-1:0] chr_code_q, chr_code_d, host_rd_q, host_rd_d;
    logic [7:0]         chr_col_q, chr_col_d;
    logic               chr_vld_q, chr_vld_d;

    // Offsets wrap below the window start, so one unsigned compare covers both bounds.
    assign h_off    = H_CTR_i - H_FETCH_ST;
    assign v_off    = V_CTR_i - V_ST;
    assign trig     = CKE_i && v_off < V_SZ && h_off < H_SZ && h_off[C_CELL_W_LOG2-1:0] == '0;
    assign disp_col = 8'(h_off >> C_CELL_W_LOG2);
    assign disp_adr = C_ADR_W'(((v_off >> C_CELL_H_LOG2) << C_PITCH_LOG2) + (h_off >> C_CELL_W_LOG2));

`ifdef CHR_VRAM_ARB_BLANK_ONLY_EN
    assign host_go = state_q == IDLE && HOST_REQ_i && !trig && !XV_BLANK_i;
`else
    logic unused_blank;
    assign unused_blank = XV_BLANK_i;
    assign host_go = state_q == IDLE && HOST_REQ_i && !trig;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = host_go ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = ACK;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en_d   = trig || host_go;
        mem_we_d   = host_go && HOST_WE_i;
        mem_adr_d  = trig ? disp_adr : host_go ? HOST_ADR_i : mem_adr_q;
        mem_wd_d   = host_go ? HOST_WD_i : mem_wd_q;
        tag1_d     = trig ? TAG_DISP : host_go ? (HOST_WE_i ? TAG_HWR : TAG_HRD) : TAG_NONE;
        col1_d     = trig ? disp_col : col1_q;
        chr_vld_d  = tag2_q == TAG_DISP;
        chr_code_d = chr_vld_d ? MEM_RD_i : chr_code_q;
        chr_col_d  = chr_vld_d ? col2_q : chr_col_q;
        host_rd_d  = tag2_q == TAG_HRD ? MEM_RD_i : host_rd_q;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q    <= IDLE;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_adr_q  <= '0;
            mem_wd_q   <= '0;
            tag1_q     <= TAG_NONE;
            tag2_q     <= TAG_NONE;
            col1_q     <= '0;
            col2_q     <= '0;
            chr_vld_q  <= 1'b0;
            chr_code_q <= '0;
            chr_col_q  <= '0;
            host_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_adr_q  <= mem_adr_d;
            mem_wd_q   <= mem_wd_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            col1_q     <= col1_d;
            col2_q     <= col1_q;
            chr_vld_q  <= chr_vld_d;
            chr_code_q <= chr_code_d;
            chr_col_q  <= chr_col_d;
            host_rd_q  <= host_rd_d;
        end
    end

    assign HOST_ACK_o = state_q == ACK;
    assign HOST_RD_o  = host_rd_q;
    assign MEM_EN_o   = mem_en_q;
    assign MEM_WE_o   = mem_we_q;
    assign MEM_ADR_o  = mem_adr_q;
    assign MEM_WD_o   = mem_wd_q;
    assign CHR_CODE_o = chr_code_q;
    assign CHR_COL_o  = chr_col_q;
    assign CHR_VLD_o  = chr_vld_q;
endmodule
